// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg
//   Shared AHB3-Lite field widths and encodings for the default slave and
//   its fault logger. Contains no ports and no logic.
package ahb3lite_pkg;

  localparam int HTRANS_SIZE = 2;
  localparam int HSIZE_SIZE  = 3;

  localparam logic [HTRANS_SIZE-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [HTRANS_SIZE-1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [HTRANS_SIZE-1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [HTRANS_SIZE-1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb3lite_fault_log.sv
// ahb3lite_fault_log
//   Captures the first faulting access (address, direction, size) and keeps a
//   saturating count of accepted transfers. A clear pulse drops the valid flag
//   and the count but leaves the captured fields in place.
// Ports:
//   HCLK, HRESET    clock, synchronous active-high reset
//   accept_i        a transfer is being accepted this cycle
//   haddr_i, hwrite_i, hsize_i   address-phase fields to capture
//   log_clr_i       one-cycle clear pulse
//   log_*_o, acc_cnt_o           captured fields and counter
module ahb3lite_fault_log
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int CNT_SIZE   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  accept_i,
  input  logic [HADDR_SIZE-1:0] haddr_i,
  input  logic                  hwrite_i,
  input  logic [HSIZE_SIZE-1:0] hsize_i,
  input  logic                  log_clr_i,
  output logic                  log_valid_o,
  output logic [HADDR_SIZE-1:0] log_addr_o,
  output logic                  log_write_o,
  output logic [HSIZE_SIZE-1:0] log_size_o,
  output logic [CNT_SIZE-1:0]   acc_cnt_o
);

  logic                  valid_q, valid_d;
  logic [HADDR_SIZE-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [HSIZE_SIZE-1:0] size_q, size_d;
  logic [CNT_SIZE-1:0]   cnt_q, cnt_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    cnt_d   = cnt_q;

    if (log_clr_i) begin
      valid_d = 1'b0;
      cnt_d   = '0;
    end

    // An accept in the same cycle as a clear starts a fresh log: the clear
    // empties it first, then this access becomes the first fault.
    if (accept_i) begin
      if (log_clr_i)
        cnt_d = CNT_SIZE'(1);
      else if (!(&cnt_q))
        cnt_d = cnt_q + CNT_SIZE'(1);

      if (!valid_q || log_clr_i) begin
        valid_d = 1'b1;
        addr_d  = haddr_i;
        write_d = hwrite_i;
        size_d  = hsize_i;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
    end
  end

  assign log_valid_o = valid_q;
  assign log_addr_o  = addr_q;
  assign log_write_o = write_q;
  assign log_size_o  = size_q;
  assign acc_cnt_o   = cnt_q;

endmodule

// File: rtl/ahb3lite_default_slave.sv
// ahb3lite_default_slave
//   Default slave for unmapped addresses. Every accepted transfer is completed
//   after WAIT_STATES wait cycles with either a two-cycle ERROR response
//   (ERR_MODE=1) or a single OKAY cycle (ERR_MODE=0, read-as-zero,
//   write-ignored). The first faulting access is logged; irq mirrors the log.
// Ports:
//   HCLK, HRESET                 clock, synchronous active-high reset
//   HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADY   AHB address phase
//   HRDATA, HREADYOUT, HRESP     AHB data-phase response (registered)
//   log_valid, log_addr, log_write, log_size, acc_cnt, irq   fault log
//   log_clr                      clears log_valid and acc_cnt
//
// State table:
//   state   | meaning
//   IDLE    | no transfer in progress, ready OKAY
//   WAIT    | inserting wait cycles, not ready OKAY
//   ERR1    | first ERROR cycle, not ready
//   ERR2    | second ERROR cycle, ready; may accept the next transfer
//   DONE    | OKAY completion, ready; may accept the next transfer
module ahb3lite_default_slave
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int WAIT_STATES = 0,
  parameter int ERR_MODE    = 1,
  parameter int CNT_SIZE    = 8
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL,
  input  logic [HADDR_SIZE-1:0]  HADDR,
  input  logic                   HWRITE,
  input  logic [HSIZE_SIZE-1:0]  HSIZE,
  input  logic [HTRANS_SIZE-1:0] HTRANS,
  input  logic                   HREADY,
  output logic [HDATA_SIZE-1:0]  HRDATA,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic                   log_valid,
  output logic [HADDR_SIZE-1:0]  log_addr,
  output logic                   log_write,
  output logic [HSIZE_SIZE-1:0]  log_size,
  input  logic                   log_clr,
  output logic [CNT_SIZE-1:0]    acc_cnt,
  output logic                   irq
);

  localparam int WCNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WAIT_STATES);
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam bit ERR_EN   = (ERR_MODE != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2,
    ST_DONE
  } state_t;

  localparam state_t ST_RESP = ERR_EN ? ST_ERR1 : ST_DONE;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;
  logic              req;
  logic              accept;

  assign req = HREADY & HSEL &
               ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));

  // A new address phase is only looked at while the slave is ready.
  assign accept = req & ((state_q == ST_IDLE) |
                         (state_q == ST_ERR2) |
                         (state_q == ST_DONE));

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE, ST_ERR2, ST_DONE: begin
        if (accept) begin
          if (HAS_WAIT) begin
            state_d = ST_WAIT;
            wcnt_d  = WCNT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q == WCNT_W'(1))
          state_d = ST_RESP;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR
                                                                  : HRESP_OKAY;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = '0;

  ahb3lite_fault_log #(
    .HADDR_SIZE (HADDR_SIZE),
    .CNT_SIZE   (CNT_SIZE)
  ) u_fault_log (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .accept_i    (accept),
    .haddr_i     (HADDR),
    .hwrite_i    (HWRITE),
    .hsize_i     (HSIZE),
    .log_clr_i   (log_clr),
    .log_valid_o (log_valid),
    .log_addr_o  (log_addr),
    .log_write_o (log_write),
    .log_size_o  (log_size),
    .acc_cnt_o   (acc_cnt)
  );

  assign irq = log_valid;

endmodule
